// File: rtl/izh_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : izh_param_loader
// Description : Byte-stream parameter loader for the Izhikevich neuron core.
//               Receives framed updates (HEADER, A, B, C, D, CSUM) over a
//               valid/ready byte interface, validates format, checksum and
//               inter-byte timeout, and commits all four parameters
//               atomically. A single CLR_CMD byte withdraws params_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module izh_param_loader #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter logic [7:0] CLR_CMD = 8'h5A,
    parameter int         TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] param_a,
    output logic [5:0] param_b,
    output logic [5:0] param_c,
    output logic [5:0] param_d,
    output logic       params_ready,
    output logic       frame_ok,
    output logic       frame_err
);

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_A    = 3'd1;
    localparam logic [2:0] S_GET_B    = 3'd2;
    localparam logic [2:0] S_GET_C    = 3'd3;
    localparam logic [2:0] S_GET_D    = 3'd4;
    localparam logic [2:0] S_GET_CSUM = 3'd5;

    logic [2:0]  r_state,   w_state_nxt;
    logic [7:0]  r_xor,     w_xor_nxt;
    logic [15:0] r_cnt,     w_cnt_nxt;
    logic [5:0]  r_sh_a,    w_sh_a_nxt;
    logic [5:0]  r_sh_b,    w_sh_b_nxt;
    logic [5:0]  r_sh_c,    w_sh_c_nxt;
    logic [5:0]  r_sh_d,    w_sh_d_nxt;
    logic [5:0]  r_param_a, w_param_a_nxt;
    logic [5:0]  r_param_b, w_param_b_nxt;
    logic [5:0]  r_param_c, w_param_c_nxt;
    logic [5:0]  r_param_d, w_param_d_nxt;
    logic        r_ready,   w_ready_nxt;
    logic        r_ok,      w_ok_nxt;
    logic        r_err,     w_err_nxt;
    logic        r_in_ready;

    logic        w_acc;
    logic        w_bad_field;
    logic [15:0] w_cnt_inc;

    assign w_acc       = in_valid & r_in_ready;
    assign w_bad_field = (in_data[7:6] != 2'b00);
    assign w_cnt_inc   = r_cnt + 16'd1;

    // Next-state, datapath and pulse decode for the frame parser
    always_comb begin
        w_state_nxt   = r_state;
        w_xor_nxt     = r_xor;
        w_cnt_nxt     = r_cnt;
        w_sh_a_nxt    = r_sh_a;
        w_sh_b_nxt    = r_sh_b;
        w_sh_c_nxt    = r_sh_c;
        w_sh_d_nxt    = r_sh_d;
        w_param_a_nxt = r_param_a;
        w_param_b_nxt = r_param_b;
        w_param_c_nxt = r_param_c;
        w_param_d_nxt = r_param_d;
        w_ready_nxt   = r_ready;
        w_ok_nxt      = 1'b0;
        w_err_nxt     = 1'b0;

        if (r_state == S_IDLE) begin
            w_cnt_nxt = 16'd0;
            if (w_acc) begin
                if (in_data == HEADER) begin
                    w_state_nxt = S_GET_A;
                    w_xor_nxt   = HEADER;
                end else if (in_data == CLR_CMD) begin
                    w_ready_nxt = 1'b0;
                end
            end
        end else if (w_acc) begin
            w_cnt_nxt = 16'd0;
            if (r_state == S_GET_CSUM) begin
                w_state_nxt = S_IDLE;
                if (in_data == r_xor) begin
                    w_param_a_nxt = r_sh_a;
                    w_param_b_nxt = r_sh_b;
                    w_param_c_nxt = r_sh_c;
                    w_param_d_nxt = r_sh_d;
                    w_ready_nxt   = 1'b1;
                    w_ok_nxt      = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end else if (w_bad_field) begin
                // Covers HEADER/CLR_CMD arriving mid-frame as well
                w_err_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end else begin
                w_xor_nxt = r_xor ^ in_data;
                case (r_state)
                    S_GET_A: begin
                        w_sh_a_nxt  = in_data[5:0];
                        w_state_nxt = S_GET_B;
                    end
                    S_GET_B: begin
                        w_sh_b_nxt  = in_data[5:0];
                        w_state_nxt = S_GET_C;
                    end
                    S_GET_C: begin
                        w_sh_c_nxt  = in_data[5:0];
                        w_state_nxt = S_GET_D;
                    end
                    S_GET_D: begin
                        w_sh_d_nxt  = in_data[5:0];
                        w_state_nxt = S_GET_CSUM;
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end else if (w_cnt_inc == c_timeout) begin
            // An accepted byte on this edge would have taken the branch above
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 16'd0;
        end else begin
            w_cnt_nxt = w_cnt_inc;
        end
    end

    // State, shadow, committed-parameter and pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_xor      <= 8'd0;
            r_cnt      <= 16'd0;
            r_sh_a     <= 6'd0;
            r_sh_b     <= 6'd0;
            r_sh_c     <= 6'd0;
            r_sh_d     <= 6'd0;
            r_param_a  <= 6'd0;
            r_param_b  <= 6'd0;
            r_param_c  <= 6'd0;
            r_param_d  <= 6'd0;
            r_ready    <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_xor      <= w_xor_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sh_a     <= w_sh_a_nxt;
            r_sh_b     <= w_sh_b_nxt;
            r_sh_c     <= w_sh_c_nxt;
            r_sh_d     <= w_sh_d_nxt;
            r_param_a  <= w_param_a_nxt;
            r_param_b  <= w_param_b_nxt;
            r_param_c  <= w_param_c_nxt;
            r_param_d  <= w_param_d_nxt;
            r_ready    <= w_ready_nxt;
            r_ok       <= w_ok_nxt;
            r_err      <= w_err_nxt;
            r_in_ready <= 1'b1;
        end
    end

    assign in_ready     = r_in_ready;
    assign param_a      = r_param_a;
    assign param_b      = r_param_b;
    assign param_c      = r_param_c;
    assign param_d      = r_param_d;
    assign params_ready = r_ready;
    assign frame_ok     = r_ok;
    assign frame_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_izh_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_izh_param_loader
// Description : Directed self-checking bench for izh_param_loader, built
//               with TIMEOUT = 4 so the timeout boundary is short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_izh_param_loader;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] param_a, param_b, param_c, param_d;
    logic       params_ready;
    logic       frame_ok;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    izh_param_loader #(
        .HEADER (8'hA5),
        .CLR_CMD(8'h5A),
        .TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .param_a     (param_a),
        .param_b     (param_b),
        .param_c     (param_c),
        .param_d     (param_d),
        .params_ready(params_ready),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one byte from the falling edge and let the next rising edge take it
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        checks++;
        if ({param_a, param_b, param_c, param_d, params_ready, frame_ok, frame_err, in_ready} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {param_a, param_b, param_c, param_d, params_ready, frame_ok, frame_err, in_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_after_reset got %b want 1", in_ready);
        end
    endtask

    task automatic test_bad_csum();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h08);
        send_byte(8'h10); send_byte(8'h02); send_byte(8'hBD);
        checks++;
        if ({frame_err, frame_ok} !== 2'b10) begin
            errors++;
            $display("FAIL bad_csum_pulse got err=%b ok=%b want err=1 ok=0", frame_err, frame_ok);
        end
        checks++;
        if ({param_a, param_b, param_c, param_d, params_ready} !== 25'd0) begin
            errors++;
            $display("FAIL bad_csum_outputs got %h want 0", {param_a, param_b, param_c, param_d, params_ready});
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_csum_err_width got %b want 0", frame_err);
        end
    endtask

    task automatic test_good_frame();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h08);
        send_byte(8'h10); send_byte(8'h02);
        checks++;
        if (params_ready !== 1'b0 || param_a !== 6'd0) begin
            errors++;
            $display("FAIL good_no_early_commit got ready=%b a=%0d want ready=0 a=0", params_ready, param_a);
        end
        send_byte(8'hBC);
        checks++;
        if ({param_a, param_b, param_c, param_d} !== {6'd3, 6'd8, 6'd16, 6'd2}) begin
            errors++;
            $display("FAIL good_params got %0d %0d %0d %0d want 3 8 16 2", param_a, param_b, param_c, param_d);
        end
        checks++;
        if ({params_ready, frame_ok, frame_err} !== 3'b110) begin
            errors++;
            $display("FAIL good_flags got rdy=%b ok=%b err=%b want 1 1 0", params_ready, frame_ok, frame_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_ok !== 1'b0) begin
            errors++;
            $display("FAIL good_ok_width got %b want 0", frame_ok);
        end
    endtask

    task automatic test_bad_format();
        send_byte(8'hA5); send_byte(8'h40);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL format_err got %b want 1", frame_err);
        end
        checks++;
        if ({param_a, param_b, param_c, param_d, params_ready} !== {6'd3, 6'd8, 6'd16, 6'd2, 1'b1}) begin
            errors++;
            $display("FAIL format_retain got %0d %0d %0d %0d rdy=%b want 3 8 16 2 rdy=1",
                     param_a, param_b, param_c, param_d, params_ready);
        end
        // FSM must be back in IDLE: a fresh frame commits
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04); send_byte(8'hA1);
        checks++;
        if ({param_a, param_b, param_c, param_d, frame_ok} !== {6'd1, 6'd2, 6'd3, 6'd4, 1'b1}) begin
            errors++;
            $display("FAIL format_recover got %0d %0d %0d %0d ok=%b want 1 2 3 4 ok=1",
                     param_a, param_b, param_c, param_d, frame_ok);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hA5); send_byte(8'h03);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (frame_err !== (i == 4)) begin
                errors++;
                $display("FAIL timeout_idle%0d got %b want %b", i, frame_err, (i == 4));
            end
        end
        // Late byte on the 4th idle edge must be taken instead of timing out
        send_byte(8'hA5); send_byte(8'h03);
        repeat (3) @(posedge clk);
        send_byte(8'h08);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_byte_wins got err=%b want 0", frame_err);
        end
        send_byte(8'h10); send_byte(8'h02); send_byte(8'hBC);
        checks++;
        if ({param_a, param_b, param_c, param_d, frame_ok} !== {6'd3, 6'd8, 6'd16, 6'd2, 1'b1}) begin
            errors++;
            $display("FAIL timeout_late_commit got %0d %0d %0d %0d ok=%b want 3 8 16 2 ok=1",
                     param_a, param_b, param_c, param_d, frame_ok);
        end
    endtask

    task automatic test_clear();
        send_byte(8'h5A);
        checks++;
        if ({params_ready, frame_ok, frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL clear_flags got rdy=%b ok=%b err=%b want 0 0 0", params_ready, frame_ok, frame_err);
        end
        checks++;
        if ({param_a, param_b, param_c, param_d} !== {6'd3, 6'd8, 6'd16, 6'd2}) begin
            errors++;
            $display("FAIL clear_params got %0d %0d %0d %0d want 3 8 16 2", param_a, param_b, param_c, param_d);
        end
        send_byte(8'h00);
        send_byte(8'hFF);
        checks++;
        if ({params_ready, frame_ok, frame_err, param_a} !== {3'b000, 6'd3}) begin
            errors++;
            $display("FAIL stray_bytes got rdy=%b ok=%b err=%b a=%0d want 0 0 0 3",
                     params_ready, frame_ok, frame_err, param_a);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04); send_byte(8'hA1);
        checks++;
        if ({param_a, param_b, param_c, param_d, params_ready, frame_ok} !== {6'd1, 6'd2, 6'd3, 6'd4, 2'b11}) begin
            errors++;
            $display("FAIL b2b_first got %0d %0d %0d %0d rdy=%b ok=%b want 1 2 3 4 1 1",
                     param_a, param_b, param_c, param_d, params_ready, frame_ok);
        end
        send_byte(8'hA5);
        checks++;
        if (frame_ok !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ok_drop got %b want 0", frame_ok);
        end
        send_byte(8'h3F); send_byte(8'h00);
        send_byte(8'h3F); send_byte(8'h00); send_byte(8'hA5);
        checks++;
        if ({param_a, param_b, param_c, param_d, frame_ok} !== {6'd63, 6'd0, 6'd63, 6'd0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second got %0d %0d %0d %0d ok=%b want 63 0 63 0 ok=1",
                     param_a, param_b, param_c, param_d, frame_ok);
        end
    endtask

    task automatic test_async_reset();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h08);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({param_a, param_b, param_c, param_d, params_ready, in_ready} !== 26'd0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", {param_a, param_b, param_c, param_d, params_ready, in_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h08);
        send_byte(8'h10); send_byte(8'h02); send_byte(8'hBC);
        checks++;
        if ({param_a, param_b, param_c, param_d, params_ready, frame_ok} !== {6'd3, 6'd8, 6'd16, 6'd2, 2'b11}) begin
            errors++;
            $display("FAIL post_reset_commit got %0d %0d %0d %0d rdy=%b ok=%b want 3 8 16 2 1 1",
                     param_a, param_b, param_c, param_d, params_ready, frame_ok);
        end
    endtask

    initial begin
        test_reset();
        test_bad_csum();
        test_good_frame();
        test_bad_format();
        test_timeout();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
